// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared state encoding, default widths and tag-compare helper
//                for the HI/LO result holder.
//  Revision    : 1.0  initial release
// ============================================================================
package hilo_pkg;

    localparam int unsigned c_XLEN_DEFAULT  = 32;
    localparam int unsigned c_TAG_W_DEFAULT = 2;
    localparam int unsigned c_TAG_W_MAX     = 8;

    typedef enum logic [0:0] {
        HILO_IDLE    = 1'b0,
        HILO_PENDING = 1'b1
    } hilo_state_e;

    // Tags are zero-extended to c_TAG_W_MAX by the caller so one helper serves every TAG_W.
    function automatic logic tag_match(
        input logic [c_TAG_W_MAX-1:0] a,
        input logic [c_TAG_W_MAX-1:0] b
    );
        return (a == b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_half.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_half
//  Description : One XLEN-wide half of the HI/LO pair: reset, MT write,
//                result write, optional same-cycle bypass (HILO_BYPASS_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_half
    import hilo_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT
) (
    input  logic            clk_cpu,
    input  logic            reset_n,
    input  logic            mt_en,
    input  logic [XLEN-1:0] mt_data,
    input  logic            res_en,
    input  logic [XLEN-1:0] res_data,
    output logic [XLEN-1:0] half_q
);

    logic [XLEN-1:0] r_half;
    logic [XLEN-1:0] w_next;

    // The MT write is younger in program order than the completing op, so it wins.
    always_comb begin
        w_next = r_half;
        if (mt_en) begin
            w_next = mt_data;
        end else if (res_en) begin
            w_next = res_data;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (!reset_n) begin
            r_half <= '0;
        end else begin
            r_half <= w_next;
        end
    end

`ifdef HILO_BYPASS_EN
    assign half_q = w_next;
`else
    assign half_q = r_half;
`endif

endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_unit
//  Description : HI/LO holder with tagged issue/complete interlock for the
//                iterative mul/div path. Optional bypass: HILO_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int XLEN  = c_XLEN_DEFAULT,
    parameter int TAG_W = c_TAG_W_DEFAULT
) (
    input  logic             clk_cpu,
    input  logic             reset_n,
    input  logic             op_start,
    output logic [TAG_W-1:0] op_tag,
    input  logic             cancel,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic [XLEN-1:0]  res_hi,
    input  logic [XLEN-1:0]  res_lo,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [XLEN-1:0]  mt_data,
    input  logic             rd_hi_req,
    input  logic             rd_lo_req,
    output logic [XLEN-1:0]  hi_q,
    output logic [XLEN-1:0]  lo_q,
    output logic             busy,
    output logic             stall
);

    hilo_state_e      r_state;
    logic [TAG_W-1:0] r_op_tag;
    logic [TAG_W-1:0] r_exp_tag;

    logic w_pending;
    logic w_tag_hit;
    logic w_acc;
    logic w_rd_req;

    assign w_pending = (r_state == HILO_PENDING);
    assign w_tag_hit = tag_match(c_TAG_W_MAX'(res_tag), c_TAG_W_MAX'(r_exp_tag));
    assign w_acc     = res_valid & w_pending & w_tag_hit & ~cancel;
    assign w_rd_req  = rd_hi_req | rd_lo_req;

    // A new start outranks every way of leaving PENDING; any older result becomes stale.
    always_ff @(posedge clk_cpu) begin
        if (!reset_n) begin
            r_state   <= HILO_IDLE;
            r_op_tag  <= '0;
            r_exp_tag <= '0;
        end else begin
            if (op_start) begin
                r_exp_tag <= r_op_tag;
                r_op_tag  <= r_op_tag + 1'b1;
                r_state   <= HILO_PENDING;
            end else if (w_pending & (w_acc | cancel | mthi_en | mtlo_en)) begin
                r_state   <= HILO_IDLE;
            end
        end
    end

    hilo_half #(
        .XLEN (XLEN)
    ) u_hi (
        .clk_cpu  (clk_cpu),
        .reset_n  (reset_n),
        .mt_en    (mthi_en),
        .mt_data  (mt_data),
        .res_en   (w_acc),
        .res_data (res_hi),
        .half_q   (hi_q)
    );

    hilo_half #(
        .XLEN (XLEN)
    ) u_lo (
        .clk_cpu  (clk_cpu),
        .reset_n  (reset_n),
        .mt_en    (mtlo_en),
        .mt_data  (mt_data),
        .res_en   (w_acc),
        .res_data (res_lo),
        .half_q   (lo_q)
    );

    assign op_tag = r_op_tag;
    assign busy   = w_pending;

`ifdef HILO_BYPASS_EN
    // The accepted result is already forwarded on hi_q/lo_q, so the read can go now.
    assign stall = w_rd_req & w_pending & ~w_acc;
`else
    assign stall = w_rd_req & w_pending;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_unit
//  Description : Table-driven self-checking bench for hilo_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_unit;

    logic        clk_cpu = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic [1:0]  op_tag;
    logic        cancel;
    logic        res_valid;
    logic [1:0]  res_tag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        mthi_en;
    logic        mtlo_en;
    logic [31:0] mt_data;
    logic        rd_hi_req;
    logic        rd_lo_req;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy;
    logic        stall;

    always #5 clk_cpu = ~clk_cpu;

    hilo_unit #(
        .XLEN  (32),
        .TAG_W (2)
    ) dut (
        .clk_cpu   (clk_cpu),
        .reset_n   (reset_n),
        .op_start  (op_start),
        .op_tag    (op_tag),
        .cancel    (cancel),
        .res_valid (res_valid),
        .res_tag   (res_tag),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .mthi_en   (mthi_en),
        .mtlo_en   (mtlo_en),
        .mt_data   (mt_data),
        .rd_hi_req (rd_hi_req),
        .rd_lo_req (rd_lo_req),
        .hi_q      (hi_q),
        .lo_q      (lo_q),
        .busy      (busy),
        .stall     (stall)
    );

    // One row = inputs for one cycle plus the outputs expected before its edge
    // (e_hi/e_lo are register contents; acc marks an expected acceptance).
    typedef struct {
        logic        rst_n, st, cn, rv;
        logic [1:0]  rt;
        logic [31:0] rhi, rlo;
        logic        mh, ml;
        logic [31:0] md;
        logic        rdh, rdl, acc;
        logic [31:0] e_hi, e_lo;
        logic        e_busy, e_stall;
        logic [1:0]  e_tag;
    } vec_t;

    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] x_hi, x_lo;
    logic        x_stall;

    task automatic add(input int rst_n, st, cn, rv, rt, rhi, rlo, mh, ml, md,
                       rdh, rdl, ac, ehi, elo, eb, es, et);
        vec_t v;
        v.rst_n = 1'(rst_n); v.st = 1'(st); v.cn = 1'(cn); v.rv = 1'(rv);
        v.rt = 2'(rt); v.rhi = 32'(rhi); v.rlo = 32'(rlo);
        v.mh = 1'(mh); v.ml = 1'(ml); v.md = 32'(md);
        v.rdh = 1'(rdh); v.rdl = 1'(rdl); v.acc = 1'(ac);
        v.e_hi = 32'(ehi); v.e_lo = 32'(elo);
        v.e_busy = 1'(eb); v.e_stall = 1'(es); v.e_tag = 2'(et);
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset_n   = v.rst_n;
        op_start  = v.st;
        cancel    = v.cn;
        res_valid = v.rv;
        res_tag   = v.rt;
        res_hi    = v.rhi;
        res_lo    = v.rlo;
        mthi_en   = v.mh;
        mtlo_en   = v.ml;
        mt_data   = v.md;
        rd_hi_req = v.rdh;
        rd_lo_req = v.rdl;
    endtask

    task automatic idle_inputs();
        op_start = 1'b0; cancel = 1'b0; res_valid = 1'b0; res_tag = 2'd0;
        res_hi = 32'd0; res_lo = 32'd0; mthi_en = 1'b0; mtlo_en = 1'b0;
        mt_data = 32'd0; rd_hi_req = 1'b0; rd_lo_req = 1'b0;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_cpu);

        //   rst st cn rv rt rhi           rlo           mh ml md            rdh rdl acc e_hi          e_lo          eb es et
        add(1, 0, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  0,            0,            0, 0, 0);
        add(1, 0, 0, 0, 0, 0,            0,            1, 0, 32'hDEADBEEF, 0, 0, 0,  0,            0,            0, 0, 0);
        add(1, 0, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'hDEADBEEF, 0,            0, 0, 0);
        // stall and accept, result three edges after the start
        add(1, 1, 0, 0, 0, 0,            0,            0, 0, 0,            1, 0, 0,  32'hDEADBEEF, 0,            0, 0, 0);
        add(1, 0, 0, 0, 0, 0,            0,            0, 0, 0,            1, 0, 0,  32'hDEADBEEF, 0,            1, 1, 1);
        add(1, 0, 0, 0, 0, 0,            0,            0, 0, 0,            1, 0, 0,  32'hDEADBEEF, 0,            1, 1, 1);
        add(1, 0, 0, 1, 0, 1,            2,            0, 0, 0,            1, 0, 1,  32'hDEADBEEF, 0,            1, 1, 1);
        add(1, 0, 0, 0, 0, 0,            0,            0, 0, 0,            1, 0, 0,  1,            2,            0, 0, 1);
        // stale tag after cancel
        add(1, 1, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  1,            2,            0, 0, 1);
        add(1, 0, 1, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  1,            2,            1, 0, 2);
        add(1, 1, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  1,            2,            0, 0, 2);
        add(1, 0, 0, 1, 1, 32'hAAAA,     32'hBBBB,     0, 0, 0,            0, 0, 0,  1,            2,            1, 0, 3);
        add(1, 0, 0, 1, 2, 32'h11,       32'h22,       0, 0, 0,            0, 0, 1,  1,            2,            1, 0, 3);
        add(0, 0, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'h11,       32'h22,       0, 0, 3);
        // tag wrap: five start/complete pairs from tag 0
        for (int k = 0; k < 5; k++) begin
            add(1, 1, 0, 0, 0,     0,        0,        0, 0, 0, 0, 0, 0,
                (k == 0) ? 0 : 32'h100 + k - 1, (k == 0) ? 0 : 32'h200 + k - 1, 0, 0, k % 4);
            add(1, 0, 0, 1, k % 4, 32'h100 + k, 32'h200 + k, 0, 0, 0, 0, 0, 1,
                (k == 0) ? 0 : 32'h100 + k - 1, (k == 0) ? 0 : 32'h200 + k - 1, 1, 0, (k + 1) % 4);
        end
        // acc together with MTLO
        add(1, 1, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'h104,      32'h204,      0, 0, 1);
        add(1, 0, 0, 1, 1, 32'hCAFE,     32'hF00D,     0, 1, 32'h55,       0, 0, 1,  32'h104,      32'h204,      1, 0, 2);
        add(1, 0, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'hCAFE,     32'h55,       0, 0, 2);
        // MTHI while pending discards the later result
        add(1, 1, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'hCAFE,     32'h55,       0, 0, 2);
        add(1, 0, 0, 0, 0, 0,            0,            1, 0, 32'h77,       0, 1, 0,  32'hCAFE,     32'h55,       1, 1, 3);
        add(1, 0, 0, 1, 2, 32'h99,       32'h98,       0, 0, 0,            0, 0, 0,  32'h77,       32'h55,       0, 0, 3);
        add(1, 0, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'h77,       32'h55,       0, 0, 3);
        // cancel with op_start: start wins, matching result blocked, old tag stale
        add(1, 1, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'h77,       32'h55,       0, 0, 3);
        add(1, 1, 1, 1, 3, 32'h1234,     32'h5678,     0, 0, 0,            0, 0, 0,  32'h77,       32'h55,       1, 0, 0);
        add(1, 0, 0, 1, 3, 32'hEE,       32'hEF,       0, 0, 0,            0, 0, 0,  32'h77,       32'h55,       1, 0, 1);
        add(1, 0, 0, 1, 0, 32'h31,       32'h32,       0, 0, 0,            0, 1, 1,  32'h77,       32'h55,       1, 1, 1);
        // reset mid-op, late result dropped
        add(1, 1, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'h31,       32'h32,       0, 0, 1);
        add(0, 0, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  32'h31,       32'h32,       1, 0, 2);
        add(1, 0, 0, 1, 0, 32'h4,        32'h5,        0, 0, 0,            0, 0, 0,  0,            0,            0, 0, 0);
        add(1, 0, 0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0,  0,            0,            0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk_cpu);
            drive(vecs[i]);
            #1;
            x_hi    = vecs[i].e_hi;
            x_lo    = vecs[i].e_lo;
            x_stall = vecs[i].e_stall;
`ifdef HILO_BYPASS_EN
            if (vecs[i].mh)       x_hi = vecs[i].md;
            else if (vecs[i].acc) x_hi = vecs[i].rhi;
            if (vecs[i].ml)       x_lo = vecs[i].md;
            else if (vecs[i].acc) x_lo = vecs[i].rlo;
            x_stall = vecs[i].e_stall & ~vecs[i].acc;
`endif
            chk("hi_q",   i, hi_q,        x_hi);
            chk("lo_q",   i, lo_q,        x_lo);
            chk("busy",   i, 32'(busy),   32'(vecs[i].e_busy));
            chk("stall",  i, 32'(stall),  32'(x_stall));
            chk("op_tag", i, 32'(op_tag), 32'(vecs[i].e_tag));
        end

        // Long-latency result: the block waits in PENDING as long as needed.
        @(negedge clk_cpu);
        idle_inputs();
        reset_n   = 1'b1;
        op_start  = 1'b1;
        rd_lo_req = 1'b1;
        #1;
        chk("long_busy_before", 0, 32'(busy), 32'd0);
        @(negedge clk_cpu);
        op_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("long_busy",  k, 32'(busy),  32'd1);
            chk("long_stall", k, 32'(stall), 32'd1);
            @(negedge clk_cpu);
        end
        res_valid = 1'b1;
        res_tag   = 2'd0;
        res_hi    = 32'hABC;
        res_lo    = 32'hDEF;
        #1;
`ifdef HILO_BYPASS_EN
        chk("long_acc_stall", 0, 32'(stall), 32'd0);
        chk("long_acc_lo",    0, lo_q,       32'hDEF);
`else
        chk("long_acc_stall", 0, 32'(stall), 32'd1);
        chk("long_acc_lo",    0, lo_q,       32'd0);
`endif
        @(negedge clk_cpu);
        idle_inputs();
        #1;
        chk("long_hi",   0, hi_q,        32'hABC);
        chk("long_lo",   0, lo_q,        32'hDEF);
        chk("long_busy_after", 0, 32'(busy), 32'd0);
        chk("long_tag",  0, 32'(op_tag), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
